hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Each cycle it decides whether the PC, IF2ID, ID2EXE and EXE2MEM

---
 rtl/hazard_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencer for the 5-stage core. Each cycle it decides
//               whether PC, IF2ID, ID2EXE and EXE2MEM advance, hold or are
//               flushed. It handles load-use / RAW stalls, taken-branch
//               flushes and data-memory wait stalls, and keeps saturating
//               stall/flush performance counters.
// Ports       : clk, rst_n (async, active-low)
//               i_id_src1/2, i_id_src2_valid  - ID-stage source registers
//               i_exe_dest/_wb_en/_mem_r_en   - ID2EXE destination info
//               i_exe_br_taken                - branch resolved taken in EXE
//               i_mem_dest/_wb_en             - EXE2MEM destination info
//               i_mem_busy                    - data memory not ready
//               i_cnt_clr                     - clear perf counters
//               o_*_en / o_*_flush            - register advance / bubble
//               o_state_out, o_mem_timeout, o_stall_cnt, o_flush_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int FWD_EN            = 1,
   parameter int BR_PENALTY        = 1,
   parameter int MAX_WAIT          = 16,
   parameter int CNT_W             = 16,
   parameter int REG_FILE_ADDR_LEN = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [REG_FILE_ADDR_LEN-1:0] i_id_src1,
   input  logic [REG_FILE_ADDR_LEN-1:0] i_id_src2,
   input  logic                         i_id_src2_valid,
   input  logic [REG_FILE_ADDR_LEN-1:0] i_exe_dest,
   input  logic                         i_exe_wb_en,
   input  logic                         i_exe_mem_r_en,
   input  logic                         i_exe_br_taken,
   input  logic [REG_FILE_ADDR_LEN-1:0] i_mem_dest,
   input  logic                         i_mem_wb_en,
   input  logic                         i_mem_busy,
   input  logic                         i_cnt_clr,
   output logic                         o_pc_en,
   output logic                         o_if2id_en,
   output logic                         o_id2exe_en,
   output logic                         o_exe2mem_en,
   output logic                         o_if2id_flush,
   output logic                         o_id2exe_flush,
   output logic [1:0]                   o_state_out,
   output logic                         o_mem_timeout,
   output logic [CNT_W-1:0]             o_stall_cnt,
   output logic [CNT_W-1:0]             o_flush_cnt
);

   localparam logic [1:0] S_RUN      = 2'd0;
   localparam logic [1:0] S_BR_FLUSH = 2'd1;
   localparam logic [1:0] S_MEM_WAIT = 2'd2;

   localparam int BR_W   = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   localparam logic [BR_W-1:0]   c_br_init   = BR_W'(BR_PENALTY - 1);
   localparam logic [BR_W-1:0]   c_br_one    = BR_W'(1);
   localparam logic [WAIT_W-1:0] c_wait_one  = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] c_wait_max  = WAIT_W'(MAX_WAIT);
   localparam logic              c_multi_br  = (BR_PENALTY > 1);
   localparam logic              c_no_fwd    = (FWD_EN == 0);

   logic [1:0]        r_state;
   logic [1:0]        r_ret_state;
   logic [BR_W-1:0]   r_br_cnt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_timeout;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   logic       w_exe_match;
   logic       w_mem_match;
   logic       w_hz;
   logic [1:0] w_eff_state;
   logic       w_br_event;
   logic       w_pc_en;
   logic       w_if2id_en;
   logic       w_id2exe_en;
   logic       w_exe2mem_en;
   logic       w_if2id_flush;
   logic       w_id2exe_flush;

   // ---------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------
   assign w_exe_match = (i_exe_dest != '0) &&
                        ((i_exe_dest == i_id_src1) ||
                         (i_id_src2_valid && (i_exe_dest == i_id_src2)));
   assign w_mem_match = (i_mem_dest != '0) &&
                        ((i_mem_dest == i_id_src1) ||
                         (i_id_src2_valid && (i_mem_dest == i_id_src2)));

   // Load-use always stalls; without forwarding any in-flight writer does.
   assign w_hz = (i_exe_wb_en && i_exe_mem_r_en && w_exe_match) ||
                 (c_no_fwd && ((i_exe_wb_en && w_exe_match) ||
                               (i_mem_wb_en && w_mem_match)));

   // When the memory wait ends, the cycle behaves as the interrupted state.
   assign w_eff_state = (r_state == S_MEM_WAIT) ? r_ret_state : r_state;

   // ---------------------------------------------------------------------
   // Enables / flushes (zero latency)
   // ---------------------------------------------------------------------
   always_comb begin
      w_pc_en        = 1'b0;
      w_if2id_en     = 1'b0;
      w_id2exe_en    = 1'b0;
      w_exe2mem_en   = 1'b0;
      w_if2id_flush  = 1'b0;
      w_id2exe_flush = 1'b0;
      w_br_event     = 1'b0;
      if (!rst_n) begin
         w_if2id_flush  = 1'b1;
         w_id2exe_flush = 1'b1;
      end else if (!i_mem_busy) begin
         w_pc_en      = 1'b1;
         w_if2id_en   = 1'b1;
         w_id2exe_en  = 1'b1;
         w_exe2mem_en = 1'b1;
         case (w_eff_state)
            S_BR_FLUSH: begin
               w_if2id_flush  = 1'b1;
               w_id2exe_flush = 1'b1;
            end
            default: begin
               if (i_exe_br_taken) begin
                  // Branch beats a hazard: the stalled ID instruction is squashed anyway.
                  w_if2id_flush  = 1'b1;
                  w_id2exe_flush = 1'b1;
                  w_br_event     = 1'b1;
               end else if (w_hz) begin
                  w_pc_en        = 1'b0;
                  w_if2id_en     = 1'b0;
                  w_id2exe_flush = 1'b1;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // State machine
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_RUN;
         r_ret_state <= S_RUN;
         r_br_cnt    <= '0;
         r_wait_cnt  <= '0;
         r_timeout   <= 1'b0;
      end else if (i_mem_busy) begin
         if (r_state != S_MEM_WAIT) begin
            r_ret_state <= r_state;
            r_wait_cnt  <= c_wait_one;
            r_state     <= S_MEM_WAIT;
         end else begin
            if (r_wait_cnt == c_wait_last) begin
               r_timeout <= 1'b1;
            end
            if (r_wait_cnt != c_wait_max) begin
               r_wait_cnt <= r_wait_cnt + c_wait_one;
            end
         end
      end else begin
         r_wait_cnt <= '0;
         case (w_eff_state)
            S_BR_FLUSH: begin
               r_br_cnt <= r_br_cnt - c_br_one;
               r_state  <= (r_br_cnt == c_br_one) ? S_RUN : S_BR_FLUSH;
            end
            default: begin
               if (w_br_event && c_multi_br) begin
                  r_state  <= S_BR_FLUSH;
                  r_br_cnt <= c_br_init;
               end else begin
                  r_state <= S_RUN;
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Saturating performance counters; clear wins over increment
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (i_cnt_clr) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!w_pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_br_event && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign o_pc_en        = w_pc_en;
   assign o_if2id_en     = w_if2id_en;
   assign o_id2exe_en    = w_id2exe_en;
   assign o_exe2mem_en   = w_exe2mem_en;
   assign o_if2id_flush  = w_if2id_flush;
   assign o_id2exe_flush = w_id2exe_flush;
   assign o_state_out    = r_state;
   assign o_mem_timeout  = r_timeout;
   assign o_stall_cnt    = r_stall_cnt;
   assign o_flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances share the
//               stimulus: A (forwarding, 2-cycle branch penalty, 8-cycle
//               timeout) and B (no forwarding, 3-cycle penalty, 4-cycle
//               timeout, 3-bit counters so saturation is reachable).
//               Control outputs are compared as a 6-bit word
//               {pc, if2id, id2exe, exe2mem, if2id_flush, id2exe_flush}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam logic [5:0] GO    = 6'b111100;
   localparam logic [5:0] STALL = 6'b001101;
   localparam logic [5:0] FL    = 6'b111111;
   localparam logic [5:0] HOLD  = 6'b000000;
   localparam logic [5:0] RSTV  = 6'b000011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
   logic       id_src2_valid, exe_wb_en, exe_mem_r_en, exe_br_taken;
   logic       mem_wb_en, mem_busy, cnt_clr;

   logic        a_pc, a_if, a_id, a_ex, a_iff, a_idf, a_to;
   logic [1:0]  a_state;
   logic [15:0] a_stall, a_flush;
   logic        b_pc, b_if, b_id, b_ex, b_iff, b_idf, b_to;
   logic [1:0]  b_state;
   logic [2:0]  b_stall, b_flush;
   logic [5:0]  ctl_a, ctl_b;

   assign ctl_a = {a_pc, a_if, a_id, a_ex, a_iff, a_idf};
   assign ctl_b = {b_pc, b_if, b_id, b_ex, b_iff, b_idf};

   hazard_ctrl #(.FWD_EN(1), .BR_PENALTY(2), .MAX_WAIT(8), .CNT_W(16), .REG_FILE_ADDR_LEN(5)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .i_id_src1(id_src1), .i_id_src2(id_src2), .i_id_src2_valid(id_src2_valid),
      .i_exe_dest(exe_dest), .i_exe_wb_en(exe_wb_en), .i_exe_mem_r_en(exe_mem_r_en),
      .i_exe_br_taken(exe_br_taken), .i_mem_dest(mem_dest), .i_mem_wb_en(mem_wb_en),
      .i_mem_busy(mem_busy), .i_cnt_clr(cnt_clr),
      .o_pc_en(a_pc), .o_if2id_en(a_if), .o_id2exe_en(a_id), .o_exe2mem_en(a_ex),
      .o_if2id_flush(a_iff), .o_id2exe_flush(a_idf), .o_state_out(a_state),
      .o_mem_timeout(a_to), .o_stall_cnt(a_stall), .o_flush_cnt(a_flush)
   );

   hazard_ctrl #(.FWD_EN(0), .BR_PENALTY(3), .MAX_WAIT(4), .CNT_W(3), .REG_FILE_ADDR_LEN(5)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .i_id_src1(id_src1), .i_id_src2(id_src2), .i_id_src2_valid(id_src2_valid),
      .i_exe_dest(exe_dest), .i_exe_wb_en(exe_wb_en), .i_exe_mem_r_en(exe_mem_r_en),
      .i_exe_br_taken(exe_br_taken), .i_mem_dest(mem_dest), .i_mem_wb_en(mem_wb_en),
      .i_mem_busy(mem_busy), .i_cnt_clr(cnt_clr),
      .o_pc_en(b_pc), .o_if2id_en(b_if), .o_id2exe_en(b_id), .o_exe2mem_en(b_ex),
      .o_if2id_flush(b_iff), .o_id2exe_flush(b_idf), .o_state_out(b_state),
      .o_mem_timeout(b_to), .o_stall_cnt(b_stall), .o_flush_cnt(b_flush)
   );

   typedef struct {
      logic [4:0] src1;
      logic [4:0] src2;
      logic       src2v;
      logic [4:0] edst;
      logic       ewb;
      logic       emr;
      logic [4:0] mdst;
      logic       mwb;
      logic [5:0] exp_a;
      logic [5:0] exp_b;
   } vec_t;

   vec_t vecs[12];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic vec_t mk(input logic [4:0] s1, input logic [4:0] s2, input logic s2v,
                               input logic [4:0] ed, input logic ew, input logic em,
                               input logic [4:0] md, input logic mw,
                               input logic [5:0] ea, input logic [5:0] eb);
      vec_t v;
      v.src1 = s1; v.src2 = s2; v.src2v = s2v; v.edst = ed; v.ewb = ew; v.emr = em;
      v.mdst = md; v.mwb = mw; v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_in();
      id_src1 = '0; id_src2 = '0; id_src2_valid = 1'b0;
      exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_br_taken = 1'b0;
      mem_dest = '0; mem_wb_en = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
   endtask

   // Advance to just after the next active edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_in();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic load_use5();
      exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 5'd5; id_src1 = 5'd5;
   endtask

   initial begin
      // Hazard table (RUN state, no branch, no memory wait)
      vecs[0]  = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, STALL, STALL); // load-use src1
      vecs[1]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, GO,    GO);    // r0 never hazards
      vecs[2]  = mk(5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, GO,    GO);    // src2 unused
      vecs[3]  = mk(5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, STALL, STALL); // src2 used
      vecs[4]  = mk(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, GO,    STALL); // ALU RAW vs EXE
      vecs[5]  = mk(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, GO,    STALL); // RAW vs MEM
      vecs[6]  = mk(5'd1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, GO,    GO);    // MEM vs unused src2
      vecs[7]  = mk(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, GO,    GO);    // MEM no writeback
      vecs[8]  = mk(5'd6, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, GO,    GO);    // load, no WB
      vecs[9]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, GO,    GO);    // MEM dest r0
      vecs[10] = mk(5'd2, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, STALL, STALL); // load-use src2
      vecs[11] = mk(5'd1, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, GO,    STALL); // ALU RAW src2

      // ---- Reset state (async, before any clock edge) ----
      clear_in();
      rst_n = 1'b0;
      #3;
      chk("reset_ctl_a", 32'(ctl_a), 32'(RSTV));
      chk("reset_ctl_b", 32'(ctl_b), 32'(RSTV));
      chk("reset_state_a", 32'(a_state), 32'd0);
      chk("reset_cnts_a", {a_stall, a_flush}, 32'd0);
      chk("reset_timeout", {30'd0, a_to, b_to}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---- Table-driven hazard vectors ----
      for (int i = 0; i < 12; i++) begin
         id_src1 = vecs[i].src1; id_src2 = vecs[i].src2; id_src2_valid = vecs[i].src2v;
         exe_dest = vecs[i].edst; exe_wb_en = vecs[i].ewb; exe_mem_r_en = vecs[i].emr;
         mem_dest = vecs[i].mdst; mem_wb_en = vecs[i].mwb;
         #2;
         chk($sformatf("vec%0d_a", i), 32'(ctl_a), 32'(vecs[i].exp_a));
         chk($sformatf("vec%0d_b", i), 32'(ctl_b), 32'(vecs[i].exp_b));
         tick();
      end

      // ---- Load-use stall lasts one cycle and is counted ----
      do_reset();
      load_use5();
      #2 chk("lu_stall_a", 32'(ctl_a), 32'(STALL));
      tick();
      exe_dest = 5'd0; id_src1 = 5'd0;
      #2 chk("lu_release_a", 32'(ctl_a), 32'(GO));
      chk("lu_stall_cnt_a", 32'(a_stall), 32'd1);
      chk("lu_stall_cnt_b", 32'(b_stall), 32'd1);
      tick();
      chk("lu_stall_cnt_hold", 32'(a_stall), 32'd1);

      // ---- Taken branch with a same-cycle hazard; bubble ignores branch ----
      do_reset();
      load_use5();
      exe_br_taken = 1'b1;
      #2 chk("br0_a", 32'(ctl_a), 32'(FL));
      chk("br0_b", 32'(ctl_b), 32'(FL));
      tick();
      clear_in();
      exe_br_taken = 1'b1;   // must be ignored inside BR_FLUSH
      #2 chk("br1_a", 32'(ctl_a), 32'(FL));
      chk("br1_state_a", 32'(a_state), 32'd1);
      chk("br1_b", 32'(ctl_b), 32'(FL));
      tick();
      exe_br_taken = 1'b0;
      #2 chk("br2_a", 32'(ctl_a), 32'(GO));
      chk("br2_state_a", 32'(a_state), 32'd0);
      chk("br2_b", 32'(ctl_b), 32'(FL));
      tick();
      #2 chk("br3_b", 32'(ctl_b), 32'(GO));
      chk("br_flush_cnt_a", 32'(a_flush), 32'd1);
      chk("br_flush_cnt_b", 32'(b_flush), 32'd1);
      chk("br_stall_cnt_a", 32'(a_stall), 32'd0);

      // ---- Memory wait in the middle of a branch flush ----
      do_reset();
      exe_br_taken = 1'b1;
      tick();
      exe_br_taken = 1'b0;
      mem_busy = 1'b1;
      #2 chk("bw1_a", 32'(ctl_a), 32'(HOLD));
      chk("bw1_state_a", 32'(a_state), 32'd1);
      tick();
      #2 chk("bw2_state_a", 32'(a_state), 32'd2);
      tick();
      mem_busy = 1'b0;
      #2 chk("bw3_a", 32'(ctl_a), 32'(FL));
      chk("bw3_b", 32'(ctl_b), 32'(FL));
      tick();
      #2 chk("bw4_a", 32'(ctl_a), 32'(GO));
      chk("bw4_b", 32'(ctl_b), 32'(FL));
      tick();
      #2 chk("bw5_b", 32'(ctl_b), 32'(GO));
      chk("bw_state_b", 32'(b_state), 32'd0);

      // ---- Memory waits, timeout and counter saturation ----
      do_reset();
      mem_busy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2 chk($sformatf("mw3_c%0d_a", c), 32'(ctl_a), 32'(HOLD));
         chk($sformatf("mw3_c%0d_b", c), 32'(ctl_b), 32'(HOLD));
         tick();
      end
      mem_busy = 1'b0;
      #2 chk("mw3_done_a", 32'(ctl_a), 32'(GO));
      chk("mw3_timeout", {30'd0, a_to, b_to}, 32'd0);
      tick();
      chk("mw3_state_a", 32'(a_state), 32'd0);
      chk("mw3_stall_a", 32'(a_stall), 32'd3);
      mem_busy = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      chk("mw4_timeout_b", 32'(b_to), 32'd1);
      chk("mw4_timeout_a", 32'(a_to), 32'd0);
      for (int c = 0; c < 3; c++) tick();
      chk("mw7_timeout_a", 32'(a_to), 32'd0);
      tick();
      chk("mw8_timeout_a", 32'(a_to), 32'd1);
      mem_busy = 1'b0;
      tick();
      tick();
      chk("mw_sticky", {30'd0, a_to, b_to}, 32'd3);
      chk("mw_stall_a", 32'(a_stall), 32'd11);
      chk("mw_stall_sat_b", 32'(b_stall), 32'd7);

      // ---- Async reset mid-BR_FLUSH ----
      do_reset();
      exe_br_taken = 1'b1;
      tick();
      exe_br_taken = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state_a", 32'(a_state), 32'd0);
      chk("arst_cnt_a", {a_stall, a_flush}, 32'd0);
      chk("arst_ctl_a", 32'(ctl_a), 32'(RSTV));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      #2 chk("arst_after_a", 32'(ctl_a), 32'(GO));

      // ---- Counter clear beats increment ----
      do_reset();
      load_use5();
      tick();
      tick();
      chk("clr_pre_stall_a", 32'(a_stall), 32'd2);
      cnt_clr = 1'b1;
      tick();
      chk("clr_stall_a", 32'(a_stall), 32'd0);
      clear_in();
      exe_br_taken = 1'b1;
      cnt_clr = 1'b1;
      tick();
      chk("clr_flush_a", 32'(a_flush), 32'd0);
      chk("clr_flush_b", 32'(b_flush), 32'd0);
      clear_in();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
